// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store memory master: size encodings,
// the load tag layout and the byte-lane helper functions.
package lsu_mem_master_pkg;

  typedef enum logic [1:0] {
    LSU_SZ_B   = 2'd0,
    LSU_SZ_H   = 2'd1,
    LSU_SZ_W   = 2'd2,
    LSU_SZ_RSV = 2'd3
  } lsu_size_e;

  // Tag kept per outstanding load: lane offset, access size, sign-extend flag
  typedef struct packed {
    logic [1:0] offset;
    lsu_size_e  size;
    logic       sign;
  } lsu_tag_t;

  localparam int LSU_TAG_W = $bits(lsu_tag_t);

  // Reserved size is always treated as misaligned
  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      LSU_SZ_B: is_misaligned = 1'b0;
      LSU_SZ_H: is_misaligned = offset[0];
      LSU_SZ_W: is_misaligned = (offset != 2'b00);
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input lsu_size_e size, input logic [1:0] offset);
    case (size)
      LSU_SZ_B: byte_enables = 4'b0001 << offset;
      LSU_SZ_H: byte_enables = 4'b0011 << offset;
      LSU_SZ_W: byte_enables = 4'hF;
      default:  byte_enables = 4'h0;
    endcase
  endfunction

  // Replicate right-justified store data onto every lane it could land in
  function automatic logic [31:0] replicate_wdata(input lsu_size_e size, input logic [31:0] data);
    case (size)
      LSU_SZ_B: replicate_wdata = {4{data[7:0]}};
      LSU_SZ_H: replicate_wdata = {2{data[15:0]}};
      default:  replicate_wdata = data;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then zero/sign extend
  function automatic logic [31:0] align_extend(input logic [31:0] data, input lsu_tag_t tag);
    logic [31:0] shifted;
    shifted = data >> {tag.offset, 3'b000};
    case (tag.size)
      LSU_SZ_B: align_extend = {{24{tag.sign & shifted[7]}}, shifted[7:0]};
      LSU_SZ_H: align_extend = {{16{tag.sign & shifted[15]}}, shifted[15:0]};
      default:  align_extend = shifted;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_sync_fifo.sv
// Small synchronous FIFO with asynchronous active-low reset. Push is ignored
// when full and pop when empty; a simultaneous push and pop both take effect.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = store[rd_ptr];

  // Storage array, written only on an effective push
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; wrap explicitly so non-power-of-two depths work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the byte-enabled data memory: decodes requests into
// registered one-cycle strobes, tracks outstanding loads in a tag FIFO and
// aligns/extends the returned read data in issue order.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int DM_AW           = 10,
  parameter int DM_DW           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             req_wr,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [DM_AW-1:0] req_addr,
  input  logic [DM_DW-1:0] req_wdata,
  output logic [DM_AW-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [DM_DW-1:0] mem_wdata,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  input  logic [DM_DW-1:0] mem_rdata,
  input  logic             mem_rdata_vld,
  output logic             rsp_vld,
  output logic [DM_DW-1:0] rsp_data,
  output logic             misalign_err,
  output logic             proto_err
);

  lsu_size_e  size;
  logic [1:0] offset;
  logic       misaligned;
  logic       accept;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  lsu_tag_t   push_tag;
  lsu_tag_t   pop_tag;

  assign size       = lsu_size_e'(req_size);
  assign offset     = req_addr[1:0];
  assign misaligned = is_misaligned(size, offset);
  assign req_rdy    = ~fifo_full;
  assign accept     = req_vld & req_rdy;
  assign push       = accept & ~req_wr & ~misaligned;
  assign pop        = mem_rdata_vld & ~fifo_empty;

  assign push_tag.offset = offset;
  assign push_tag.size   = size;
  assign push_tag.sign   = req_signed;

  sync_fifo #(
    .WIDTH (LSU_TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_tag),
    .pop       (pop),
    .pop_data  (pop_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Memory-side register stage: strobes live for exactly one cycle after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      mem_wr_en    <= 1'b0;
      mem_rd_en    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      mem_wr_en    <= accept & req_wr & ~misaligned;
      mem_rd_en    <= accept & ~req_wr & ~misaligned;
      misalign_err <= accept & misaligned;
      if (accept) begin
        mem_addr  <= req_addr;
        mem_be    <= misaligned ? 4'h0 : byte_enables(size, offset);
        mem_wdata <= replicate_wdata(size, req_wdata);
      end
    end
  end

  // Response stage: align/extend popped data; flag returns with nothing outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld   <= 1'b0;
      rsp_data  <= '0;
      proto_err <= 1'b0;
    end else begin
      rsp_vld <= pop;
      if (pop) rsp_data <= align_extend(mem_rdata, pop_tag);
      if (mem_rdata_vld & fifo_empty) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a behavioural
// byte-enabled memory whose read delay can be changed between tests.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_rdata_vld;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        misalign_err;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  int          rd_delay = 1;
  logic        inj_vld = 1'b0;
  logic [31:0] mem_words [0:255];
  logic        pv [1:8];
  logic [31:0] pd [1:8];

  lsu_mem_master #(
    .DM_AW (10),
    .DM_DW (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_wr        (req_wr),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_wr_en     (mem_wr_en),
    .mem_rd_en     (mem_rd_en),
    .mem_rdata     (mem_rdata),
    .mem_rdata_vld (mem_rdata_vld),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
    .misalign_err  (misalign_err),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data appears rd_delay cycles after the mem_rd_en cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= 8; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= 32'h0;
      end
    end else begin
      for (int i = 8; i > 1; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      pv[1] <= mem_rd_en;
      pd[1] <= mem_words[mem_addr[9:2]];
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_words[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign mem_rdata_vld = pv[rd_delay] | inj_vld;
  assign mem_rdata     = pd[rd_delay];

  // Drive one request across a single accepting edge; returns at the negedge of T+1
  task automatic drive_req(input logic wr, input logic [1:0] size, input logic sgn,
                           input logic [9:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_vld    = 1'b1;
    req_wr     = wr;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_wr_en, mem_rd_en, mem_be, rsp_vld, misalign_err, proto_err} !== 9'h0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b want 0", {mem_wr_en, mem_rd_en, mem_be, rsp_vld, misalign_err, proto_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_data} !== 74'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, rsp_data});
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_rdy: got %b want 1", req_rdy);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    drive_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF);
    checks++;
    if ({mem_wr_en, mem_rd_en} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL sw_strobes: got %b want 10", {mem_wr_en, mem_rd_en});
    end
    checks++;
    if (mem_be !== 4'hF) begin
      errors++;
      $display("[TB] FAIL sw_be: got %h want f", mem_be);
    end
    checks++;
    if (mem_addr !== 10'h010) begin
      errors++;
      $display("[TB] FAIL sw_addr: got %h want 010", mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL sw_wdata: got %h want deadbeef", mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({mem_wr_en, mem_rd_en} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL sw_strobe_drop: got %b want 00", {mem_wr_en, mem_rd_en});
    end
  endtask

  task automatic test_store_byte();
    drive_req(1'b1, 2'd0, 1'b0, 10'h013, 32'h000000A5);
    checks++;
    if (mem_be !== 4'h8) begin
      errors++;
      $display("[TB] FAIL sb_be: got %h want 8", mem_be);
    end
    checks++;
    if (mem_wdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("[TB] FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata);
    end
    drive_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    checks++;
    if ({mem_wr_en, mem_rd_en} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL lw_strobes: got %b want 01", {mem_wr_en, mem_rd_en});
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lw_early_rsp: got %b want 0", rsp_vld);
    end
    @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== 32'hA5ADBEEF) begin
      errors++;
      $display("[TB] FAIL lw_reread: got vld=%b data=%h want vld=1 data=a5adbeef", rsp_vld, rsp_data);
    end
  endtask

  task automatic test_load_extend();
    logic [9:0]  addr_t [6] = '{10'h013, 10'h013, 10'h012, 10'h010, 10'h011, 10'h010};
    logic [1:0]  size_t [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    logic        sgn_t  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_t  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8056,
                                32'h00003412, 32'h00000034, 32'h80563412};
    drive_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h80563412);
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b0, size_t[i], sgn_t[i], addr_t[i], 32'h0);
      repeat (2) @(negedge clk);
      checks++;
      if (rsp_vld !== 1'b1 || rsp_data !== exp_t[i]) begin
        errors++;
        $display("[TB] FAIL load_ext_%0d: got vld=%b data=%h want vld=1 data=%h", i, rsp_vld, rsp_data, exp_t[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [9:0] addr_t [3] = '{10'h011, 10'h012, 10'h010};
    logic [1:0] size_t [3] = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, size_t[i], 1'b0, addr_t[i], 32'h0);
      checks++;
      if ({misalign_err, mem_wr_en, mem_rd_en, req_rdy} !== 4'b1001) begin
        errors++;
        $display("[TB] FAIL misalign_%0d: got err/wr/rd/rdy=%b want 1001", i, {misalign_err, mem_wr_en, mem_rd_en, req_rdy});
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (rsp_vld !== 1'b0 || misalign_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL misalign_after_%0d: got rsp_vld=%b err=%b want 0 0", i, rsp_vld, misalign_err);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_vld = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 10'h040; req_wdata = 32'h11223344;
    @(negedge clk);
    req_wr = 1'b0; req_size = 2'd1; req_addr = 10'h042; req_wdata = 32'h0;
    checks++;
    if ({mem_wr_en, mem_rd_en} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_store: got %b want 10", {mem_wr_en, mem_rd_en});
    end
    @(negedge clk);
    req_vld = 1'b0;
    checks++;
    if ({mem_wr_en, mem_rd_en, mem_be} !== 6'b01_1100) begin
      errors++;
      $display("[TB] FAIL b2b_load: got wr/rd/be=%b want 011100", {mem_wr_en, mem_rd_en, mem_be});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_vld !== 1'b1 || rsp_data !== 32'h00001122) begin
      errors++;
      $display("[TB] FAIL b2b_rsp: got vld=%b data=%h want vld=1 data=00001122", rsp_vld, rsp_data);
    end
  endtask

  task automatic test_outstanding();
    logic [9:0]  addr_t [5] = '{10'h020, 10'h027, 10'h02A, 10'h02C, 10'h030};
    logic [1:0]  size_t [5] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic        sgn_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp_t  [5] = '{32'hCAFEF00D, 32'hFFFFFF9A, 32'h00001357, 32'h2468ACE0, 32'h0000003C};
    logic [31:0] got [$];
    int idx = 0;
    int rise = -1;
    logic rdy_at4 = 1'b1;
    drive_req(1'b1, 2'd2, 1'b0, 10'h020, 32'hCAFEF00D);
    drive_req(1'b1, 2'd2, 1'b0, 10'h024, 32'h9ABCDEF0);
    drive_req(1'b1, 2'd2, 1'b0, 10'h028, 32'h13579BDF);
    drive_req(1'b1, 2'd2, 1'b0, 10'h02C, 32'h2468ACE0);
    drive_req(1'b1, 2'd2, 1'b0, 10'h030, 32'h0F1E2D3C);
    repeat (2) @(negedge clk);
    rd_delay = 4;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_vld === 1'b1) got.push_back(rsp_data);
      if (c == 4) rdy_at4 = req_rdy;
      if (c >= 4 && req_rdy === 1'b1 && rise < 0) rise = c;
      if (idx < 5) begin
        req_vld = 1'b1; req_wr = 1'b0; req_size = size_t[idx];
        req_signed = sgn_t[idx]; req_addr = addr_t[idx]; req_wdata = 32'h0;
        if (req_rdy === 1'b1) idx++;
      end else begin
        req_vld = 1'b0;
      end
    end
    req_vld = 1'b0;
    rd_delay = 1;
    checks++;
    if (rdy_at4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_rdy_drop: got %b want 0", rdy_at4);
    end
    checks++;
    if (rise != 6) begin
      errors++;
      $display("[TB] FAIL full_rdy_rise: got cycle %0d want 6", rise);
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("[TB] FAIL out_count: got %0d want 5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_t[i]) begin
          errors++;
          $display("[TB] FAIL out_data_%0d: got %h want %h", i, got[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_proto_err();
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proto_pre: got %b want 0", proto_err);
    end
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || rsp_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proto_set: got err=%b rsp_vld=%b want 1 0", proto_err, rsp_vld);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (proto_err !== 1'b1 || rsp_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proto_hold: got err=%b rsp_vld=%b want 1 0", proto_err, rsp_vld);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL proto_clear: got %b want 0", proto_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_vld = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_extend();
    test_misalign();
    test_back_to_back();
    test_outstanding();
    test_proto_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
